multiply_divide_unit: RTL

Iterative MIPS multiply/divide unit in the execute stage, beside the ALU: takes the same decoded operand pair, computes MULT/MULTU/DIV/DIVU into the architectural HI/LO pair, and services MTHI/MTLO. The execute-stage result mux reads HI/LO for MFHI/MFLO. Hazard logic stalls on `busy`.

---
 rtl/multiply_divide_unit_if.sv | 25 ++
 rtl/multiply_divide_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multiply_divide_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The master side drives requests; the slave side (the unit) returns status and HI/LO.
interface multiply_divide_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       operator;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, operator, operand1, operand2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, operator, operand1, operand2, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multiply_divide_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with MTHI/MTLO, owning the HI/LO pair.
// Define MULTIPLY_DIVIDE_UNIT_FAST_MULTIPLY_EN for a single-cycle multiply path.
//
// state  | meaning
// IDLE   | waiting; accepts MULT/DIV (-> RUN) or MTHI/MTLO (direct write)
// RUN    | one shift-add or restoring-divide step per cycle, counter down to 0
// FINISH | sign correction and HI/LO write, unless flushed
module multiply_divide_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  multiply_divide_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand_b;
  logic [WIDTH-1:0]   dividend_raw;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CW-1:0]      count;
  logic               is_div, res_neg, rem_neg, div_zero, done_q;

  logic               is_md, is_signed, op_div, idle_take;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2;

  always_comb begin
    is_md     = 1'b0;
    is_signed = 1'b0;
    op_div    = 1'b0;
    case (bus.operator)
      OP_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
      OP_MULTU: begin is_md = 1'b1; end
      OP_DIV:   begin is_md = 1'b1; is_signed = 1'b1; op_div = 1'b1; end
      OP_DIVU:  begin is_md = 1'b1; op_div = 1'b1; end
      default:  ;
    endcase
  end

  // flush beats start in IDLE, including the MTHI/MTLO writes
  assign idle_take = (state == S_IDLE) && bus.start && !bus.flush;

  assign op1_neg = is_signed & bus.operand1[WIDTH-1];
  assign op2_neg = is_signed & bus.operand2[WIDTH-1];
  assign mag1    = op1_neg ? -bus.operand1 : bus.operand1;
  assign mag2    = op2_neg ? -bus.operand2 : bus.operand2;

`ifdef MULTIPLY_DIVIDE_UNIT_FAST_MULTIPLY_EN
  logic [2*WIDTH-1:0] fast_product;
  assign fast_product = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (idle_take && is_md) begin
`ifdef MULTIPLY_DIVIDE_UNIT_FAST_MULTIPLY_EN
          state_next = op_div ? S_RUN : S_FINISH;
`else
          state_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (bus.flush)              state_next = S_IDLE;
        else if (count == CW'(1))   state_next = S_FINISH;
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Multiply: {hi-half + mcand, lo-half} shifted right one bit per step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc holds remainder:quotient; a negative trial difference restores.
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, operand_b};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fin_hi = dividend_raw;
        fin_lo = '1;
      end else begin
        fin_hi = rem_neg ? -rem : rem;
        fin_lo = res_neg ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      operand_b    <= '0;
      dividend_raw <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      count        <= '0;
      is_div       <= 1'b0;
      res_neg      <= 1'b0;
      rem_neg      <= 1'b0;
      div_zero     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (idle_take && is_md) begin
            is_div       <= op_div;
            res_neg      <= op1_neg ^ op2_neg;
            rem_neg      <= op1_neg;
            div_zero     <= (bus.operand2 == '0);
            dividend_raw <= bus.operand1;
            operand_b    <= op_div ? mag2 : mag1;
            acc          <= {{WIDTH{1'b0}}, (op_div ? mag1 : mag2)};
            count        <= CW'(WIDTH);
`ifdef MULTIPLY_DIVIDE_UNIT_FAST_MULTIPLY_EN
            if (!op_div) begin
              acc   <= fast_product;
              count <= '0;
            end
`endif
          end else if (idle_take && bus.operator == OP_MTHI) begin
            hi_q <= bus.operand1;
          end else if (idle_take && bus.operator == OP_MTLO) begin
            lo_q <= bus.operand1;
          end
        end
        S_RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= bus.flush ? '0 : count - 1'b1;
        end
        S_FINISH: begin
          if (!bus.flush) begin
            hi_q   <= fin_hi;
            lo_q   <= fin_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
